// File: rtl/game_tick_scheduler_if.sv
// Handshake and control bundle between the game logic (master) and the
// tick scheduler (slave).
interface game_tick_scheduler_if;
  logic       run;
  logic       step;
  logic       level_up;
  logic       level_clr;
  logic       tick_ack;
  logic       tick;
  logic [2:0] level;
  logic [7:0] overrun_cnt;
  logic [1:0] state;

  modport master (
    output run, step, level_up, level_clr, tick_ack,
    input  tick, level, overrun_cnt, state
  );

  modport slave (
    input  run, step, level_up, level_clr, tick_ack,
    output tick, level, overrun_cnt, state
  );
endinterface

// File: rtl/game_tick_scheduler.sv
// Snake game step cadence: issues a tick request every `period` clocks,
// where period shrinks with a saturating speed level. Supports pause,
// single-step while paused, and a saturating count of unserviced ticks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | paused, cnt held at 0; step issues one tick
// S_COUNT | free-running, counting toward the next tick
// S_REQ   | tick raised, waiting for ack; cnt keeps cadence while running
module game_tick_scheduler #(
  parameter int BASE_PERIOD = 12500000,
  parameter int PERIOD_STEP = 1250000,
  parameter int MIN_PERIOD  = 2500000,
  parameter int CNT_W       = 25
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  game_tick_scheduler_if.slave  sched
);

  // Wide enough that level*PERIOD_STEP never overflows.
  localparam int PW = CNT_W + 3;
  localparam logic [PW-1:0] BASE_W     = PW'(BASE_PERIOD);
  localparam logic [PW-1:0] MIN_W      = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] HEADROOM_W = PW'(BASE_PERIOD - MIN_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REQ   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_tick;
  logic [2:0]       r_level;
  logic [7:0]       r_overrun;
  logic             w_overrun_evt;
  logic [PW-1:0]    w_step_total;
  logic [PW-1:0]    w_period;
  logic             w_expire;

  // Period from level; comparing against the headroom avoids ever
  // forming a negative intermediate.
  always_comb begin
    w_step_total = PW'(r_level) * PW'(PERIOD_STEP);
    if (w_step_total > HEADROOM_W) begin
      w_period = MIN_W;
    end else begin
      w_period = BASE_W - w_step_total;
    end
  end

  // >= so a level change that drops the period below cnt expires at once.
  assign w_expire  = ({3'b000, r_cnt} >= (w_period - PW'(1)));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state, counter and overrun-event decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_overrun_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (sched.run) begin
          w_state_nxt = S_COUNT;
        end else if (sched.step) begin
          w_state_nxt = S_REQ;
        end
      end
      S_COUNT: begin
        if (!sched.run) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_expire) begin
          w_state_nxt = S_REQ;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_REQ: begin
        if (sched.run) begin
          if (w_expire) begin
            w_cnt_nxt     = '0;
            w_overrun_evt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_cnt_nxt = '0;
        end
        // Ack does not touch cnt, so cadence is independent of ack latency.
        if (sched.tick_ack) begin
          w_state_nxt = sched.run ? S_COUNT : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered tick.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= (w_state_nxt == S_REQ);
    end
  end

  // Speed level: clear wins over increment, increment saturates at 7.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level <= '0;
    end else if (sched.level_clr) begin
      r_level <= '0;
    end else if (sched.level_up && (r_level != 3'd7)) begin
      r_level <= r_level + 3'd1;
    end
  end

  // Missed-tick count: cleared with the level, saturates at 255.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overrun <= '0;
    end else if (sched.level_clr) begin
      r_overrun <= '0;
    end else if (w_overrun_evt && (r_overrun != 8'hFF)) begin
      r_overrun <= r_overrun + 8'd1;
    end
  end

  assign sched.tick        = r_tick;
  assign sched.level       = r_level;
  assign sched.overrun_cnt = r_overrun;
  assign sched.state       = r_state;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler with small periods (10/2/4, 8-bit counter).
// Expected tick rise cycles are queued as stimulus is driven and compared
// by a monitor whenever tick rises.
module tb_game_tick_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   exp_t;
  int   t0;
  logic tick_q = 1'b0;

  game_tick_scheduler_if sif ();

  game_tick_scheduler #(
    .BASE_PERIOD(10),
    .PERIOD_STEP(2),
    .MIN_PERIOD (4),
    .CNT_W      (8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sched(sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every tick rise must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sif.tick === 1'b1 && tick_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tick_unexpected", cyc, 0);
      end else begin
        exp_t = exp_q.pop_front();
        chk("tick_time", cyc, exp_t);
      end
    end
    tick_q = sif.tick;
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int bound);
    int k = 0;
    while (sif.tick !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (sif.tick !== 1'b1) chk("rise_timeout", 32'(sif.tick), 1);
  endtask

  task automatic ack_pulse();
    sif.tick_ack = 1'b1;
    @(negedge clk);
    sif.tick_ack = 1'b0;
    chk("ack_fall", 32'(sif.tick), 0);
  endtask

  task automatic start_run(input int period);
    sif.run = 1'b1;
    exp_q.push_back(cyc + 1 + period);
  endtask

  task automatic run_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      wait_rise(period + 5);
      if (i < n - 1) exp_q.push_back(cyc + period);
      ack_pulse();
    end
  endtask

  task automatic pause();
    sif.run = 1'b0;
    @(negedge clk);
  endtask

  task automatic lvl_up(input int n);
    repeat (n) begin
      sif.level_up = 1'b1;
      @(negedge clk);
      sif.level_up = 1'b0;
    end
  endtask

  task automatic lvl_clr(input bit with_up);
    sif.level_clr = 1'b1;
    sif.level_up  = with_up;
    @(negedge clk);
    sif.level_clr = 1'b0;
    sif.level_up  = 1'b0;
  endtask

  initial begin
    sif.run       = 1'b0;
    sif.step      = 1'b0;
    sif.level_up  = 1'b0;
    sif.level_clr = 1'b0;
    sif.tick_ack  = 1'b0;
    nclk(3);
    rst = 1'b0;
    nclk(1);
    chk("rst_tick",  32'(sif.tick), 0);
    chk("rst_level", 32'(sif.level), 0);
    chk("rst_ovr",   32'(sif.overrun_cnt), 0);
    chk("rst_state", 32'(sif.state), 0);

    // Free-run at level 0
    start_run(10);
    run_ticks(4, 10);
    chk("free_ovr", 32'(sif.overrun_cnt), 0);
    pause();
    chk("pause_state", 32'(sif.state), 0);

    // Level saturation
    lvl_up(3);
    chk("level_3", 32'(sif.level), 3);
    start_run(4);
    run_ticks(3, 4);
    pause();
    lvl_up(5);
    chk("level_7", 32'(sif.level), 7);
    start_run(4);
    run_ticks(2, 4);
    pause();
    lvl_clr(1'b1);
    chk("level_clr_wins", 32'(sif.level), 0);
    start_run(10);
    run_ticks(2, 10);
    pause();

    // Overrun: ack sampled 25 cycles after the rise
    start_run(10);
    wait_rise(15);
    t0 = cyc;
    nclk(24);
    chk("ovr_tick_held", 32'(sif.tick), 1);
    chk("ovr_state_req", 32'(sif.state), 2);
    chk("ovr_count", 32'(sif.overrun_cnt), 2);
    sif.tick_ack = 1'b1;
    @(negedge clk);
    sif.tick_ack = 1'b0;
    chk("ovr_ack_fall", 32'(sif.tick), 0);
    exp_q.push_back(t0 + 30);
    run_ticks(1, 10);
    pause();
    chk("ovr_kept", 32'(sif.overrun_cnt), 2);
    lvl_clr(1'b0);
    chk("ovr_clr", 32'(sif.overrun_cnt), 0);

    // Pause and single step
    nclk(50);
    chk("paused_state", 32'(sif.state), 0);
    chk("paused_tick", 32'(sif.tick), 0);
    sif.step = 1'b1;
    exp_q.push_back(cyc + 1);
    @(negedge clk);
    sif.step = 1'b0;
    chk("step_tick", 32'(sif.tick), 1);
    chk("step_state", 32'(sif.state), 2);
    nclk(2);
    sif.step = 1'b1;
    @(negedge clk);
    sif.step = 1'b0;
    ack_pulse();
    chk("step_idle", 32'(sif.state), 0);
    nclk(5);
    start_run(10);
    @(negedge clk);
    sif.step = 1'b1;
    @(negedge clk);
    sif.step = 1'b0;
    run_ticks(1, 10);
    pause();

    // Mid-count level change lands below the running count
    start_run(10);
    wait_rise(15);
    t0 = cyc;
    exp_q.push_back(t0 + 8);
    ack_pulse();
    nclk(4);
    sif.level_up = 1'b1;
    nclk(2);
    chk("mid_no_early", 32'(sif.tick), 0);
    nclk(1);
    sif.level_up = 1'b0;
    chk("mid_tick", 32'(sif.tick), 1);
    chk("mid_level", 32'(sif.level), 3);
    ack_pulse();
    pause();
    lvl_clr(1'b0);

    // Reset while a tick is outstanding
    lvl_up(1);
    start_run(8);
    wait_rise(13);
    nclk(9);
    chk("pre_rst_tick", 32'(sif.tick), 1);
    chk("pre_rst_ovr", 32'(sif.overrun_cnt), 1);
    rst = 1'b1;
    #1;
    chk("async_tick",  32'(sif.tick), 0);
    chk("async_level", 32'(sif.level), 0);
    chk("async_ovr",   32'(sif.overrun_cnt), 0);
    chk("async_state", 32'(sif.state), 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(cyc + 1 + 10);
    run_ticks(1, 10);
    pause();

    nclk(3);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
